// File: rtl/uart_rx_frame_check_if.sv
// ----------------------------------------------------------------------------
// uart_rx_frame_check_if
// Bundles the bit-sampler side strobes, the frame configuration and the result
// outputs of the UART RX frame checker.
//   master : drives frame_start, bit_valid, sampled_bit, par_en, par_mode,
//            err_clr; observes the result signals
//   slave  : the frame checker; drives P_DATA, data_valid, parity_error,
//            stop_error, par_err_cnt, stop_err_cnt
// Parameters DATA_WIDTH / CNT_WIDTH must match the attached checker.
// ----------------------------------------------------------------------------
interface uart_rx_frame_check_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  frame_start;
  logic                  bit_valid;
  logic                  sampled_bit;
  logic                  par_en;
  logic [1:0]            par_mode;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  parity_error;
  logic                  stop_error;
  logic [CNT_WIDTH-1:0]  par_err_cnt;
  logic [CNT_WIDTH-1:0]  stop_err_cnt;

  modport master (
    output frame_start, bit_valid, sampled_bit, par_en, par_mode, err_clr,
    input  P_DATA, data_valid, parity_error, stop_error, par_err_cnt, stop_err_cnt
  );

  modport slave (
    input  frame_start, bit_valid, sampled_bit, par_en, par_mode, err_clr,
    output P_DATA, data_valid, parity_error, stop_error, par_err_cnt, stop_err_cnt
  );
endinterface

// File: rtl/uart_rx_frame_check.sv
// ----------------------------------------------------------------------------
// uart_rx_frame_check
// Serial frame checker behind the UART bit sampler. Assembles DATA_WIDTH data
// bits LSB-first, accumulates parity on the fly, checks the optional parity
// bit (even/odd/mark/space) and the stop bit, then presents the word and the
// error flags with a one-cycle data_valid pulse.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - uart_rx_frame_check_if.slave (strobes, config, results)
// Build option:
//   UART_RX_ERR_CNT_EN - when defined, saturating parity/stop error counters
//                        with err_clr are built; otherwise they read 0.
// ----------------------------------------------------------------------------
module uart_rx_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_rx_frame_check_if.slave bus
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Expected parity bit from the mode and the XOR of the data bits.
  function automatic logic expected_parity(input logic [1:0] mode, input logic run_par);
    logic exp_v;
    case (mode)
      2'b00:   exp_v = run_par;
      2'b01:   exp_v = ~run_par;
      2'b10:   exp_v = 1'b1;
      2'b11:   exp_v = 1'b0;
      default: exp_v = 1'b0;
    endcase
    return exp_v;
  endfunction

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         cnt_q, cnt_d;
  logic                  run_par_q, run_par_d;
  logic                  par_en_q, par_en_d;
  logic [1:0]            par_mode_q, par_mode_d;
  logic                  par_err_q, par_err_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;

  // frame_start always wins over a same-cycle bit strobe, which is dropped.
  logic start_s, data_bit_s, par_bit_s, stop_bit_s;
  assign start_s    = bus.frame_start;
  assign data_bit_s = !bus.frame_start && bus.bit_valid && (state_q == S_DATA);
  assign par_bit_s  = !bus.frame_start && bus.bit_valid && (state_q == S_PARITY);
  assign stop_bit_s = !bus.frame_start && bus.bit_valid && (state_q == S_STOP);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; frame_start from any state (re)starts a frame.
  always_comb begin
    state_d = state_q;
    if (start_s) begin
      state_d = S_DATA;
    end else if (bus.bit_valid) begin
      case (state_q)
        S_IDLE:   state_d = S_IDLE;
        S_DATA: begin
          if (cnt_q == LAST_BIT) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Datapath and output next values driven by the current state strobes.
  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    run_par_d  = run_par_q;
    par_en_d   = par_en_q;
    par_mode_d = par_mode_q;
    par_err_d  = par_err_q;
    if (start_s) begin
      shift_d    = '0;
      cnt_d      = '0;
      run_par_d  = 1'b0;
      par_en_d   = bus.par_en;
      par_mode_d = bus.par_mode;
      par_err_d  = 1'b0;
    end else if (data_bit_s) begin
      // Right shift: the first received bit ends up in bit 0.
      shift_d   = {bus.sampled_bit, shift_q[DATA_WIDTH-1:1]};
      cnt_d     = cnt_q + BW'(1);
      run_par_d = run_par_q ^ bus.sampled_bit;
    end else if (par_bit_s) begin
      par_err_d = expected_parity(par_mode_q, run_par_q) ^ bus.sampled_bit;
    end else begin
      par_err_d = par_err_q;
    end

    valid_d = stop_bit_s;
    if (stop_bit_s) begin
      // par_err_q stays 0 for frames without a parity bit.
      p_data_d = shift_q;
      perr_d   = par_err_q;
      serr_d   = ~bus.sampled_bit;
    end else begin
      p_data_d = p_data_q;
      perr_d   = perr_q;
      serr_d   = serr_q;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      run_par_q  <= 1'b0;
      par_en_q   <= 1'b0;
      par_mode_q <= 2'b00;
      par_err_q  <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      run_par_q  <= run_par_d;
      par_en_q   <= par_en_d;
      par_mode_q <= par_mode_d;
      par_err_q  <= par_err_d;
      p_data_q   <= p_data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
    end
  end

  assign bus.P_DATA       = p_data_q;
  assign bus.data_valid   = valid_q;
  assign bus.parity_error = perr_q;
  assign bus.stop_error   = serr_q;

`ifdef UART_RX_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] par_cnt_q;
  logic [CNT_WIDTH-1:0] stop_cnt_q;

  // Saturating error counters, bumped on the data_valid cycle; clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_cnt_q  <= '0;
      stop_cnt_q <= '0;
    end else if (bus.err_clr) begin
      par_cnt_q  <= '0;
      stop_cnt_q <= '0;
    end else begin
      if (valid_q && perr_q && (par_cnt_q != {CNT_WIDTH{1'b1}})) begin
        par_cnt_q <= par_cnt_q + CNT_WIDTH'(1);
      end else begin
        par_cnt_q <= par_cnt_q;
      end
      if (valid_q && serr_q && (stop_cnt_q != {CNT_WIDTH{1'b1}})) begin
        stop_cnt_q <= stop_cnt_q + CNT_WIDTH'(1);
      end else begin
        stop_cnt_q <= stop_cnt_q;
      end
    end
  end

  assign bus.par_err_cnt  = par_cnt_q;
  assign bus.stop_err_cnt = stop_cnt_q;
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = bus.err_clr;
  assign bus.par_err_cnt  = '0;
  assign bus.stop_err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_frame_check
// Drives an 8-bit and a 5-bit instance of uart_rx_frame_check (both with
// 2-bit counters). 'sel' routes the strobes to one instance and its results
// back. Expected words/flags come from a frame-level model: parity from the
// popcount of the data word, counters as saturating integers.
// ----------------------------------------------------------------------------
module tb_uart_rx_frame_check;

`ifdef UART_RX_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       sel;
  logic       fs, bv, sb, pe, clr;
  logic [1:0] pm;

  uart_rx_frame_check_if #(.DATA_WIDTH(8), .CNT_WIDTH(2)) if8 ();
  uart_rx_frame_check_if #(.DATA_WIDTH(5), .CNT_WIDTH(2)) if5 ();

  uart_rx_frame_check #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  uart_rx_frame_check #(.DATA_WIDTH(5), .CNT_WIDTH(2)) dut5 (.clk(clk), .rst(rst), .bus(if5));

  assign if8.frame_start = fs & ~sel;
  assign if8.bit_valid   = bv & ~sel;
  assign if8.err_clr     = clr & ~sel;
  assign if8.sampled_bit = sb;
  assign if8.par_en      = pe;
  assign if8.par_mode    = pm;
  assign if5.frame_start = fs & sel;
  assign if5.bit_valid   = bv & sel;
  assign if5.err_clr     = clr & sel;
  assign if5.sampled_bit = sb;
  assign if5.par_en      = pe;
  assign if5.par_mode    = pm;

  logic [15:0] o_data;
  logic        o_valid, o_perr, o_serr;
  logic [1:0]  o_pcnt, o_scnt;
  assign o_data  = sel ? {11'd0, if5.P_DATA} : {8'd0, if8.P_DATA};
  assign o_valid = sel ? if5.data_valid   : if8.data_valid;
  assign o_perr  = sel ? if5.parity_error : if8.parity_error;
  assign o_serr  = sel ? if5.stop_error   : if8.stop_error;
  assign o_pcnt  = sel ? if5.par_err_cnt  : if8.par_err_cnt;
  assign o_scnt  = sel ? if5.stop_err_cnt : if8.stop_err_cnt;

  int errors = 0;
  int checks = 0;
  int vcnt   = 0;
  int mpc[2];
  int msc[2];

  // Count data_valid pulses of the selected instance.
  always @(negedge clk) if (o_valid === 1'b1) vcnt++;

  // Reference: parity error for a frame, from the popcount of the data word.
  function automatic logic model_perr(input logic [15:0] d, input int n, input logic pen,
                                      input logic [1:0] m, input logic pb);
    int ones;
    logic exp_b;
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(d[i]);
    case (m)
      2'b00:   exp_b = (ones % 2) == 1;
      2'b01:   exp_b = (ones % 2) == 0;
      2'b10:   exp_b = 1'b1;
      default: exp_b = 1'b0;
    endcase
    return pen && (exp_b != pb);
  endfunction

  // Reference: counter update for one delivered frame.
  task automatic model_counters(input int s, input logic perr, input logic serr, input bit c);
    if (CNT_EN) begin
      if (c) begin
        mpc[s] = 0; msc[s] = 0;
      end else begin
        if (perr && mpc[s] < 3) mpc[s]++;
        if (serr && msc[s] < 3) msc[s]++;
      end
    end
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // One full frame; returns what was seen one cycle after the stop strobe
  // (od..oserr) and one cycle later (ov2, counters).
  task automatic send_frame(input bit s, input int n, input logic [15:0] d, input logic pe_v,
                            input logic [1:0] pm_v, input logic pb, input logic stb,
                            input bit collide, input bit clr_v,
                            output logic [15:0] od, output logic ov, output logic ov2,
                            output logic operr, output logic oserr,
                            output logic [1:0] opc, output logic [1:0] osc);
    @(negedge clk);
    sel = s; vcnt = 0;
    fs = 1'b1; pe = pe_v; pm = pm_v; bv = collide; sb = ~d[0];
    @(negedge clk);
    fs = 1'b0; bv = 1'b0;
    pe = 1'($urandom); pm = 2'($urandom);   // mid-frame config noise
    for (int i = 0; i < n; i++) begin
      gap();
      bv = 1'b1; sb = d[i];
      @(negedge clk);
      bv = 1'b0;
    end
    if (pe_v) begin
      gap();
      bv = 1'b1; sb = pb;
      @(negedge clk);
      bv = 1'b0;
    end
    gap();
    bv = 1'b1; sb = stb;
    @(negedge clk);
    bv = 1'b0; clr = clr_v;
    od = o_data; ov = o_valid; operr = o_perr; oserr = o_serr;
    @(negedge clk);
    clr = 1'b0;
    ov2 = o_valid; opc = o_pcnt; osc = o_scnt;
  endtask

  task automatic test_reset();
    checks++;
    if ({if8.P_DATA, if8.data_valid, if8.parity_error, if8.stop_error,
         if8.par_err_cnt, if8.stop_err_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL reset8: got data=%h v=%b pe=%b se=%b pc=%0d sc=%0d, want all 0",
               if8.P_DATA, if8.data_valid, if8.parity_error, if8.stop_error,
               if8.par_err_cnt, if8.stop_err_cnt);
    end
    checks++;
    if ({if5.P_DATA, if5.data_valid, if5.parity_error, if5.stop_error,
         if5.par_err_cnt, if5.stop_err_cnt} !== 12'd0) begin
      errors++;
      $display("FAIL reset5: got data=%h v=%b pe=%b se=%b pc=%0d sc=%0d, want all 0",
               if5.P_DATA, if5.data_valid, if5.parity_error, if5.stop_error,
               if5.par_err_cnt, if5.stop_err_cnt);
    end
  endtask

  // Directed frames: {data, par_en, mode, parity bit, stop bit, exp perr, exp serr}.
  task automatic test_directed();
    logic [15:0] td[6] = '{16'hA5, 16'h01, 16'h01, 16'h3C, 16'h3C, 16'h3C};
    logic        tpe[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0]  tpm[6] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00};
    logic        tpb[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        tsb[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        xpe[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        xse[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] od;
    logic ov, ov2, operr, oserr;
    logic [1:0] opc, osc;
    for (int k = 0; k < 6; k++) begin
      send_frame(1'b0, 8, td[k], tpe[k], tpm[k], tpb[k], tsb[k], 1'b0, 1'b0,
                 od, ov, ov2, operr, oserr, opc, osc);
      model_counters(0, xpe[k], xse[k], 1'b0);
      checks++;
      if (od !== td[k] || ov !== 1'b1 || ov2 !== 1'b0 || operr !== xpe[k] || oserr !== xse[k]) begin
        errors++;
        $display("FAIL directed[%0d]: got data=%h v=%b v+1=%b pe=%b se=%b, want data=%h v=1 v+1=0 pe=%b se=%b",
                 k, od, ov, ov2, operr, oserr, td[k], xpe[k], xse[k]);
      end
    end
  endtask

  // Abort after 4 bits, then a full 0x5A frame: a single delivery.
  task automatic test_abort();
    logic [15:0] od;
    logic ov, ov2, operr, oserr;
    logic [1:0] opc, osc;
    @(negedge clk);
    sel = 1'b0; vcnt = 0; fs = 1'b1; pe = 1'b0;
    @(negedge clk);
    fs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bv = 1'b1; sb = 1'($urandom);
      @(negedge clk);
      bv = 1'b0;
    end
    checks++;
    if (vcnt !== 0) begin
      errors++;
      $display("FAIL abort_partial: got %0d data_valid pulses, want 0", vcnt);
    end
    send_frame(1'b0, 8, 16'h5A, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0,
               od, ov, ov2, operr, oserr, opc, osc);
    model_counters(0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (vcnt !== 1 || od !== 16'h5A) begin
      errors++;
      $display("FAIL abort_frame: got pulses=%0d data=%h, want pulses=1 data=005a", vcnt, od);
    end
  endtask

  task automatic test_random();
    logic [15:0] od, d;
    logic ov, ov2, operr, oserr, pe_v, pb, stb, xp;
    logic [1:0] opc, osc, pm_v;
    bit s, col, c;
    int n;
    for (int k = 0; k < 40; k++) begin
      s = 1'($urandom); n = s ? 5 : 8;
      d = 16'($urandom) & ((16'd1 << n) - 16'd1);
      pe_v = 1'($urandom); pm_v = 2'($urandom); pb = 1'($urandom);
      stb = ($urandom_range(0, 3) != 0); col = 1'($urandom);
      c = ($urandom_range(0, 7) == 0);
      send_frame(s, n, d, pe_v, pm_v, pb, stb, col, c, od, ov, ov2, operr, oserr, opc, osc);
      xp = model_perr(d, n, pe_v, pm_v, pb);
      model_counters(int'(s), xp, ~stb, c);
      checks++;
      if (od !== d || ov !== 1'b1 || ov2 !== 1'b0 || operr !== xp || oserr !== ~stb || vcnt !== 1) begin
        errors++;
        $display("FAIL random[%0d] w=%0d: got data=%h v=%b v+1=%b pe=%b se=%b pulses=%0d, want data=%h v=1 v+1=0 pe=%b se=%b pulses=1",
                 k, n, od, ov, ov2, operr, oserr, vcnt, d, xp, ~stb);
      end
      checks++;
      if (int'(opc) !== mpc[s] || int'(osc) !== msc[s]) begin
        errors++;
        $display("FAIL random_cnt[%0d]: got pc=%0d sc=%0d, want pc=%0d sc=%0d",
                 k, opc, osc, mpc[s], msc[s]);
      end
    end
  endtask

  // Five parity-error frames saturate at 3; clear on the valid cycle wins.
  task automatic test_counters();
    logic [15:0] od;
    logic ov, ov2, operr, oserr;
    logic [1:0] opc, osc;
    @(negedge clk);
    sel = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; mpc[0] = 0; msc[0] = 0;
    for (int k = 0; k < 5; k++) begin
      send_frame(1'b0, 8, 16'h01, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0,
                 od, ov, ov2, operr, oserr, opc, osc);
      model_counters(0, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (int'(opc) !== mpc[0] || opc !== (CNT_EN ? 2'd3 : 2'd0)) begin
      errors++;
      $display("FAIL cnt_saturate: got pc=%0d, want %0d", opc, mpc[0]);
    end
    send_frame(1'b0, 8, 16'h01, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1,
               od, ov, ov2, operr, oserr, opc, osc);
    model_counters(0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (opc !== 2'd0 || osc !== 2'd0 || operr !== 1'b1) begin
      errors++;
      $display("FAIL cnt_clear: got pc=%0d sc=%0d pe=%b, want pc=0 sc=0 pe=1", opc, osc, operr);
    end
  endtask

  // 5-bit frame, then a reset in the middle of a frame.
  task automatic test_width5_reset();
    logic [15:0] od;
    logic ov, ov2, operr, oserr;
    logic [1:0] opc, osc;
    send_frame(1'b1, 5, 16'h13, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0,
               od, ov, ov2, operr, oserr, opc, osc);
    model_counters(1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (od !== 16'h13 || operr !== 1'b0 || oserr !== 1'b0 || ov !== 1'b1) begin
      errors++;
      $display("FAIL width5: got data=%h pe=%b se=%b v=%b, want data=0013 pe=0 se=0 v=1",
               od, operr, oserr, ov);
    end
    @(negedge clk);
    vcnt = 0; fs = 1'b1; pe = 1'b1; pm = 2'b00;
    @(negedge clk);
    fs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bv = 1'b1; sb = 1'b1;
      @(negedge clk);
      bv = 1'b0;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (o_data !== 16'd0 || o_valid !== 1'b0 || o_perr !== 1'b0 || o_serr !== 1'b0 ||
        o_pcnt !== 2'd0 || o_scnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: got data=%h v=%b pe=%b se=%b pc=%0d sc=%0d, want all 0",
               o_data, o_valid, o_perr, o_serr, o_pcnt, o_scnt);
    end
    mpc = '{0, 0}; msc = '{0, 0};
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin   // rest of the frame, now ignored
      bv = 1'b1; sb = 1'b0;
      @(negedge clk);
      bv = 1'b0;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (vcnt !== 0 || o_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_no_output: got pulses=%0d data=%h, want pulses=0 data=0000", vcnt, o_data);
    end
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; fs = 1'b0; bv = 1'b0; sb = 1'b0;
    pe = 1'b0; pm = 2'b00; clr = 1'b0;
    mpc = '{0, 0}; msc = '{0, 0};
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    test_directed();
    test_abort();
    test_random();
    test_counters();
    test_width5_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
